// File: rtl/aes_key_expand_pkg.sv
// Shared types, geometry constants and small helpers for the AES key expander.
package aes_key_expand_pkg;
    localparam int ROW_STRIDE = 120;
    localparam int WORD_AW    = 9;
    localparam int KEY_AW     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } state_t;

    // Element 0 is byte row 0, i.e. the most significant byte of the FIPS word.
    typedef logic [0:3][7:0] col_t;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [5:0] nc_of(input logic [3:0] nk);
        logic [5:0] t;
        t = {2'b00, nk} + 6'd7;
        return t << 2;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_key_expand_if.sv
// Block handshake, key RAM read ports and round-key write ports of the key expander.
interface aes_key_expand_if;
    import aes_key_expand_pkg::*;

    logic               ap_start;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic [1:0]         key_len;
    logic [KEY_AW-1:0]  key_address0;
    logic               key_ce0;
    logic [31:0]        key_q0;
    logic [KEY_AW-1:0]  key_address1;
    logic               key_ce1;
    logic [31:0]        key_q1;
    logic [WORD_AW-1:0] word_address0;
    logic               word_ce0;
    logic               word_we0;
    logic [31:0]        word_d0;
    logic [WORD_AW-1:0] word_address1;
    logic               word_ce1;
    logic               word_we1;
    logic [31:0]        word_d1;

    modport slave (
        input  ap_start, key_len, key_q0, key_q1,
        output ap_done, ap_idle, ap_ready,
        output key_address0, key_ce0, key_address1, key_ce1,
        output word_address0, word_ce0, word_we0, word_d0,
        output word_address1, word_ce1, word_we1, word_d1
    );

    modport master (
        output ap_start, key_len, key_q0, key_q1,
        input  ap_done, ap_idle, ap_ready,
        input  key_address0, key_ce0, key_address1, key_ce1,
        input  word_address0, word_ce0, word_we0, word_d0,
        input  word_address1, word_ce1, word_we1, word_d1
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign o_out = SBOX[i_in];
endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 KeyExpansion: loads the key from a dual-port RAM and writes the
// expanded schedule as byte rows, two bytes per cycle, one column per two cycles.
module aes_key_expand
    import aes_key_expand_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    aes_key_expand_if.slave    bus
);
    localparam logic [WORD_AW-1:0] ROW1 = WORD_AW'(ROW_STRIDE);
    localparam logic [WORD_AW-1:0] ROW2 = WORD_AW'(2 * ROW_STRIDE);
    localparam logic [WORD_AW-1:0] ROW3 = WORD_AW'(3 * ROW_STRIDE);

    state_t     r_state, w_next;
    logic [3:0] r_nk;
    logic [5:0] r_nc;
    logic [3:0] r_k;
    logic       r_rd_vld;
    logic [3:0] r_rd_k;
    logic [5:0] r_j;
    logic [2:0] r_jmod;
    logic [7:0] r_rcon;
    col_t       r_win [8];
    col_t       r_col;

    col_t       w_prev, w_old, w_sin, w_sout, w_col;
    logic       w_gen, w_rot, w_sub4;
    logic       w_unused_q;

    assign w_unused_q = ^{bus.key_q0[31:8], bus.key_q1[31:8]};

    // Window holds w[j-nk] at slot 0 and w[j-1] at slot nk-1 once generation begins.
    assign w_prev = r_win[3'(r_nk - 4'd1)];
    assign w_old  = r_win[0];
    assign w_gen  = (r_j >= {2'b00, r_nk});
    assign w_rot  = (r_jmod == 3'd0);
    assign w_sub4 = (r_nk == 4'd8) && (r_jmod == 3'd4);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.i_in(w_sin[g]), .o_out(w_sout[g]));
    end

    always_comb begin
        w_sin = w_rot ? {w_prev[1], w_prev[2], w_prev[3], w_prev[0]} : w_prev;
        if (!w_gen)
            w_col = r_win[r_j[2:0]];
        else if (w_rot)
            w_col = w_sout ^ w_old ^ {r_rcon, 24'd0};
        else if (w_sub4)
            w_col = w_sout ^ w_old;
        else
            w_col = w_prev ^ w_old;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.ap_start) w_next = ST_LOAD;
            ST_LOAD:  if ({1'b0, r_k} == ({r_nk, 1'b0} - 5'd1)) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_WR_LO;
            ST_WR_LO: w_next = ST_WR_HI;
            ST_WR_HI: w_next = (r_j == r_nc - 6'd1) ? ST_DONE : ST_WR_LO;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ap_done       = (r_state == ST_DONE);
        bus.ap_ready      = (r_state == ST_DONE);
        bus.ap_idle       = (r_state == ST_IDLE) && !bus.ap_start;
        bus.key_address0  = '0;
        bus.key_address1  = '0;
        bus.key_ce0       = 1'b0;
        bus.key_ce1       = 1'b0;
        bus.word_address0 = '0;
        bus.word_address1 = '0;
        bus.word_ce0      = 1'b0;
        bus.word_ce1      = 1'b0;
        bus.word_we0      = 1'b0;
        bus.word_we1      = 1'b0;
        bus.word_d0       = '0;
        bus.word_d1       = '0;
        case (r_state)
            ST_LOAD: begin
                bus.key_address0 = {r_k, 1'b0};
                bus.key_address1 = {r_k, 1'b1};
                bus.key_ce0      = 1'b1;
                bus.key_ce1      = 1'b1;
            end
            ST_WR_LO: begin
                bus.word_address0 = WORD_AW'(r_j);
                bus.word_address1 = ROW1 + WORD_AW'(r_j);
                {bus.word_ce0, bus.word_we0, bus.word_ce1, bus.word_we1} = 4'hf;
                bus.word_d0       = {24'd0, w_col[0]};
                bus.word_d1       = {24'd0, w_col[1]};
            end
            ST_WR_HI: begin
                bus.word_address0 = ROW2 + WORD_AW'(r_j);
                bus.word_address1 = ROW3 + WORD_AW'(r_j);
                {bus.word_ce0, bus.word_we0, bus.word_ce1, bus.word_we1} = 4'hf;
                bus.word_d0       = {24'd0, r_col[2]};
                bus.word_d1       = {24'd0, r_col[3]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= ST_IDLE;
            r_nk     <= 4'd4;
            r_nc     <= '0;
            r_k      <= '0;
            r_rd_vld <= 1'b0;
            r_rd_k   <= '0;
            r_j      <= '0;
            r_jmod   <= '0;
            r_rcon   <= 8'h01;
            r_col    <= '0;
            for (int c = 0; c < 8; c++) r_win[c] <= '0;
        end else begin
            r_state  <= w_next;
            r_rd_vld <= (r_state == ST_LOAD);
            r_rd_k   <= r_k;
            if (r_state == ST_IDLE && bus.ap_start) begin
                r_nk   <= nk_of(bus.key_len);
                r_nc   <= nc_of(nk_of(bus.key_len));
                r_k    <= '0;
                r_j    <= '0;
                r_jmod <= '0;
                r_rcon <= 8'h01;
            end
            if (r_state == ST_LOAD) r_k <= r_k + 4'd1;
            // Read data lags its address by one cycle; the last pair lands in DRAIN.
            if (r_rd_vld) begin
                r_win[r_rd_k[3:1]][{r_rd_k[0], 1'b0}] <= bus.key_q0[7:0];
                r_win[r_rd_k[3:1]][{r_rd_k[0], 1'b1}] <= bus.key_q1[7:0];
            end
            if (r_state == ST_WR_LO) r_col <= w_col;
            if (r_state == ST_WR_HI) begin
                r_j    <= r_j + 6'd1;
                r_jmod <= ({1'b0, r_jmod} == r_nk - 4'd1) ? 3'd0 : r_jmod + 3'd1;
                if (w_gen) begin
                    for (int c = 0; c < 8; c++) begin
                        if (c == int'(r_nk) - 1) r_win[c] <= r_col;
                        else if (c < 7)          r_win[c] <= r_win[(c + 1) % 8];
                    end
                    if (w_rot) r_rcon <= xtime(r_rcon);
                end
            end
        end
    end
endmodule
